tilelink_ul_slave_model: RTL

//  Parametrised TileLink-UL/UH slave responder for core-level formal and simulation harnesses; sits on a tile master port.

---
 rtl/tilelink_ul_slave_model.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tilelink_ul_slave_model.sv
// ============================================================================
// Module   : tilelink_ul_slave_model
// Brief    : TileLink-UL/UH slave responder with a request FIFO. It answers
//            Get with multi-beat AccessAckData and Put* with AccessAck.
//            Stall and read data come from free inputs.
//            Optional feature macro: TL_SLAVE_ERR_EN adds the err_inject input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tilelink_ul_slave_model #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SOURCE_W = 1,
  parameter int SIZE_W   = 4,
  parameter int DEPTH    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  a_ready,
  input  logic                  a_valid,
  input  logic [2:0]            a_opcode,
  input  logic [2:0]            a_param,
  input  logic [SIZE_W-1:0]     a_size,
  input  logic [SOURCE_W-1:0]   a_source,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W/8-1:0]   a_mask,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  d_ready,
  output logic                  d_valid,
  output logic [2:0]            d_opcode,
  output logic [1:0]            d_param,
  output logic                  d_sink,
  output logic [SIZE_W-1:0]     d_size,
  output logic [SOURCE_W-1:0]   d_source,
  output logic [DATA_W-1:0]     d_data,
  output logic                  d_error,
  input  logic                  stall_a,
  input  logic                  stall_d,
`ifdef TL_SLAVE_ERR_EN
  input  logic                  err_inject,
`endif
  input  logic [DATA_W-1:0]     rand_data
);

  localparam int c_BB      = DATA_W / 8;
  localparam int c_LOG2_BB = $clog2(c_BB);
  localparam int c_CNT_W   = SIZE_W + 1;
  localparam int c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_OCC_W   = $clog2(DEPTH + 1);

  function automatic logic [c_CNT_W-1:0] f_beats(input logic [SIZE_W-1:0] size);
    logic [c_CNT_W-1:0] n;
    if (int'(size) <= c_LOG2_BB) n = c_CNT_W'(1);
    else                         n = c_CNT_W'(1) << (int'(size) - c_LOG2_BB);
    return n;
  endfunction

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    logic [c_PTR_W-1:0] n;
    if (int'(p) == DEPTH - 1) n = '0;
    else                      n = p + c_PTR_W'(1);
    return n;
  endfunction

  // ---------------------------------------------------------------- A side
  logic [c_CNT_W-1:0]  r_a_cnt;
  logic [2:0]          r_a_op;
  logic [2:0]          r_a_param;
  logic [SIZE_W-1:0]   r_a_size;
  logic [SOURCE_W-1:0] r_a_src;
  logic [ADDR_W-1:0]   r_a_addr;

  logic [c_OCC_W-1:0]  r_occ;
  logic                w_full;
  logic                w_empty;
  logic                w_a_fire;
  logic                w_a_first;
  logic [2:0]          w_a_op;
  logic [SIZE_W-1:0]   w_a_size;
  logic [SOURCE_W-1:0] w_a_src;
  logic [c_CNT_W-1:0]  w_a_beats;
  logic                w_a_last;
  logic                w_push;
  logic                w_pop;

  assign w_full    = (r_occ == c_OCC_W'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign a_ready   = !reset && !stall_a && !w_full;
  assign w_a_fire  = a_valid && a_ready;
  assign w_a_first = (r_a_cnt == '0);

  // Burst header comes from the first beat; later beats reuse the latched copy.
  assign w_a_op    = w_a_first ? a_opcode : r_a_op;
  assign w_a_size  = w_a_first ? a_size   : r_a_size;
  assign w_a_src   = w_a_first ? a_source : r_a_src;
  assign w_a_beats = (w_a_op <= 3'd3) ? f_beats(w_a_size) : c_CNT_W'(1);
  assign w_a_last  = ((r_a_cnt + c_CNT_W'(1)) == w_a_beats);
  assign w_push    = w_a_fire && w_a_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_cnt   <= '0;
      r_a_op    <= '0;
      r_a_param <= '0;
      r_a_size  <= '0;
      r_a_src   <= '0;
      r_a_addr  <= '0;
    end else if (w_a_fire) begin
      r_a_cnt <= w_a_last ? '0 : (r_a_cnt + c_CNT_W'(1));
      if (w_a_first) begin
        r_a_op    <= a_opcode;
        r_a_param <= a_param;
        r_a_size  <= a_size;
        r_a_src   <= a_source;
        r_a_addr  <= a_address;
      end
    end
  end

  // ---------------------------------------------------------------- queue
  logic [2:0]          r_q_op   [DEPTH];
  logic [SIZE_W-1:0]   r_q_size [DEPTH];
  logic [SOURCE_W-1:0] r_q_src  [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_q_op[r_wr_ptr]   <= w_a_op;
        r_q_size[r_wr_ptr] <= w_a_size;
        r_q_src[r_wr_ptr]  <= w_a_src;
        r_wr_ptr           <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + c_OCC_W'(1);
        2'b01:   r_occ <= r_occ - c_OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // ---------------------------------------------------------------- D side
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_enter;
  logic [c_CNT_W-1:0]  r_d_cnt;
  logic [2:0]          w_h_op;
  logic [SIZE_W-1:0]   w_h_size;
  logic [SOURCE_W-1:0] w_h_src;
  logic [2:0]          w_rsp_op;
  logic                w_rsp_err;
  logic [c_CNT_W-1:0]  w_d_beats;
  logic                w_d_last;
  logic                w_d_fire;
  logic                w_in_resp;
  logic                w_more;
  logic                w_err_inj;

  assign w_h_op   = r_q_op[r_rd_ptr];
  assign w_h_size = r_q_size[r_rd_ptr];
  assign w_h_src  = r_q_src[r_rd_ptr];

  always_comb begin
    w_rsp_op  = 3'd0;
    w_rsp_err = 1'b0;
    case (w_h_op)
      3'd0, 3'd1: begin w_rsp_op = 3'd0; w_rsp_err = 1'b0; end
      3'd2, 3'd3: begin w_rsp_op = 3'd1; w_rsp_err = 1'b1; end
      3'd4:       begin w_rsp_op = 3'd1; w_rsp_err = 1'b0; end
      3'd5:       begin w_rsp_op = 3'd2; w_rsp_err = 1'b0; end
      default:    begin w_rsp_op = 3'd0; w_rsp_err = 1'b1; end
    endcase
  end

  assign w_in_resp = (r_state == S_RESP);
  assign w_d_beats = (w_rsp_op == 3'd1) ? f_beats(w_h_size) : c_CNT_W'(1);
  assign w_d_last  = ((r_d_cnt + c_CNT_W'(1)) == w_d_beats);
  assign d_valid   = w_in_resp && !stall_d;
  assign w_d_fire  = d_valid && d_ready;
  assign w_pop     = w_d_fire && w_d_last;
  // Entries left after this pop, counting one arriving this same cycle.
  assign w_more    = (r_occ > c_OCC_W'(1)) || w_push;

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty || w_push) begin
          w_state_nxt = S_RESP;
          w_enter     = 1'b1;
        end
      end
      S_RESP: begin
        if (w_pop) begin
          if (w_more) w_enter     = 1'b1;
          else        w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_d_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter || w_pop) r_d_cnt <= '0;
      else if (w_d_fire)    r_d_cnt <= r_d_cnt + c_CNT_W'(1);
    end
  end

`ifdef TL_SLAVE_ERR_EN
  logic r_err_inj;

  always_ff @(posedge clock) begin
    if (reset)        r_err_inj <= 1'b0;
    else if (w_enter) r_err_inj <= err_inject;
  end

  assign w_err_inj = r_err_inj;
`else
  assign w_err_inj = 1'b0;
`endif

  assign d_opcode = w_in_resp ? w_rsp_op : 3'd0;
  assign d_param  = 2'd0;
  assign d_sink   = 1'b0;
  assign d_size   = w_in_resp ? w_h_size : '0;
  assign d_source = w_in_resp ? w_h_src  : '0;
  assign d_error  = w_in_resp && (w_rsp_err || w_err_inj);
  assign d_data   = (w_in_resp && (w_rsp_op == 3'd1) && !w_err_inj) ? rand_data : '0;

endmodule

`default_nettype wire
